// File: rtl/hamming_window.sv
// Hamming window stage: reads one frame of pre-emphasised fp32 samples,
// multiplies each by its ROM coefficient and writes the product to the
// window memory, one sample at a time.

// fp32 multiplier, round-to-nearest-even. Zero/denormal operands and
// underflowing results flush to signed zero. Overflow gives infinity.
// inf*0 and NaN inputs give the canonical quiet NaN.
// MUL_LAT register stages advance only while ena is high, so data_out
// holds the last product between uses.
module mul_fp_clk #(
    parameter int MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] data_out
);
    logic        sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0] mp;
    logic [22:0] man;
    logic [23:0] manr;
    logic        g, st;
    logic [9:0]  es;
    logic [31:0] prod;
    logic [31:0] pipe [MUL_LAT];

    assign sgn    = a[31] ^ b[31];
    assign a_nan  = (&a[30:23]) && (|a[22:0]);
    assign b_nan  = (&b[30:23]) && (|b[22:0]);
    assign a_inf  = (&a[30:23]) && !(|a[22:0]);
    assign b_inf  = (&b[30:23]) && !(|b[22:0]);
    assign a_zero = (a[30:23] == 8'd0);
    assign b_zero = (b[30:23] == 8'd0);

    // combinational product: normalise, round to nearest even, classify
    always_comb begin
        mp = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        if (mp[47]) begin
            man = mp[46:24];
            g   = mp[23];
            st  = |mp[22:0];
            es  = {2'b0, a[30:23]} + {2'b0, b[30:23]} + 10'd1;
        end else begin
            man = mp[45:23];
            g   = mp[22];
            st  = |mp[21:0];
            es  = {2'b0, a[30:23]} + {2'b0, b[30:23]};
        end
        manr = {1'b0, man} + {23'd0, g & (st | man[0])};
        // mantissa carry-out leaves manr[22:0] at zero, only the exponent bumps
        if (manr[23])
            es = es + 10'd1;
        if (a_nan || b_nan)
            prod = 32'h7FC0_0000;
        else if (a_inf || b_inf)
            prod = (a_zero || b_zero) ? 32'h7FC0_0000 : {sgn, 8'hFF, 23'd0};
        else if (a_zero || b_zero)
            prod = {sgn, 31'd0};
        else if (es >= 10'd382)
            prod = {sgn, 8'hFF, 23'd0};
        else if (es <= 10'd127)
            prod = {sgn, 31'd0};
        else
            prod = {sgn, 8'(es - 10'd127), manr[22:0]};
    end

    // latency pipeline, frozen while ena is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MUL_LAT; i++) pipe[i] <= '0;
        end else if (ena) begin
            pipe[0] <= prod;
            for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign data_out = pipe[MUL_LAT-1];
endmodule

module hamming_window #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int PREEM_BASE = 0,
    parameter int MUL_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  win_state_en,
    input  logic [10:0]           sample_in_frame,
    output logic [ADDR_WIDTH-1:0] preem_mem_read_addr,
    input  logic [DATA_WIDTH-1:0] preem_data_in,
    output logic [ADDR_WIDTH-1:0] win_rom_addr,
    input  logic [DATA_WIDTH-1:0] win_coef_in,
    output logic [DATA_WIDTH-1:0] win_data_out,
    output logic [ADDR_WIDTH-1:0] win_mem_write_addr,
    output logic                  write_win_en,
    output logic                  win_busy,
    output logic                  win_done
);
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [2:0] {IDLE, RD, WAIT, MUL, WR, DONE} state_t;

    state_t          state;
    logic [10:0]     n_lat, idx;
    logic [CW-1:0]   wcnt;
    logic [31:0]     op_a, op_b;

    // The multiplier's output register is the product register; it only
    // advances in MUL, so the windowed sample holds outside WR.
    mul_fp_clk #(.MUL_LAT(MUL_LAT)) u_mul (
        .clk      (clk),
        .rst      (rst),
        .ena      (state == MUL),
        .a        (op_a),
        .b        (op_b),
        .data_out (win_data_out)
    );

    // sequencer: one sample per RD/WAIT/MUL/WR round, registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            n_lat               <= '0;
            idx                 <= '0;
            wcnt                <= '0;
            op_a                <= '0;
            op_b                <= '0;
            preem_mem_read_addr <= '0;
            win_rom_addr        <= '0;
            win_mem_write_addr  <= '0;
            write_win_en        <= 1'b0;
            win_busy            <= 1'b0;
            win_done            <= 1'b0;
        end else begin
            write_win_en <= 1'b0;
            win_done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_state_en) begin
                        n_lat <= sample_in_frame;
                        if (sample_in_frame == 11'd0) begin
                            state    <= DONE;
                            win_done <= 1'b1;
                        end else begin
                            idx                 <= '0;
                            state               <= RD;
                            win_busy            <= 1'b1;
                            preem_mem_read_addr <= ADDR_WIDTH'(PREEM_BASE);
                            win_rom_addr        <= '0;
                        end
                    end
                end
                RD: state <= WAIT;
                WAIT: begin
                    op_a  <= preem_data_in;
                    op_b  <= win_coef_in;
                    wcnt  <= '0;
                    state <= MUL;
                end
                MUL: begin
                    if (wcnt == CW'(MUL_LAT - 1)) begin
                        state              <= WR;
                        write_win_en       <= 1'b1;
                        win_mem_write_addr <= ADDR_WIDTH'(idx);
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                WR: begin
                    if (idx == n_lat - 11'd1) begin
                        state    <= DONE;
                        win_done <= 1'b1;
                        win_busy <= 1'b0;
                    end else begin
                        idx                 <= idx + 11'd1;
                        state               <= RD;
                        preem_mem_read_addr <= ADDR_WIDTH'(PREEM_BASE) + ADDR_WIDTH'(idx + 11'd1);
                        win_rom_addr        <= ADDR_WIDTH'(idx + 11'd1);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
